// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, masked write port,
// reservation handshake and pending count.
interface regfile_sb_if #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
);
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [N-1:0]  v1;
    logic [N-1:0]  v2;
    logic          b1;
    logic          b2;
    logic          we;
    logic [AW-1:0] w1;
    logic [N-1:0]  mask;
    logic [N-1:0]  w;
    logic          rsv_valid;
    logic [AW-1:0] rsv_addr;
    logic          rsv_ready;
    logic [AW:0]   pending;

    modport master (
        output r1, r2, we, w1, mask, w, rsv_valid, rsv_addr,
        input  v1, v2, b1, b2, rsv_ready, pending
    );

    modport slave (
        input  r1, r2, we, w1, mask, w, rsv_valid, rsv_addr,
        output v1, v2, b1, b2, rsv_ready, pending
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard and reservation handshake.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    logic [N-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW:0]      pending_q;
    logic [AW:0]      pending_d;

    logic         we_ok;
    logic         rsv_ok;
    logic         fire;
    logic         clr;
    logic [N-1:0] wr_old;
    logic [N-1:0] merged;
    logic [N-1:0] v1_c;
    logic [N-1:0] v2_c;
    logic         b1_c;
    logic         b2_c;

    function automatic logic in_rng(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    always_comb begin
        we_ok  = bus.we && in_rng(bus.w1);
        rsv_ok = in_rng(bus.rsv_addr) && !busy_q[bus.rsv_addr];
        fire   = bus.rsv_valid && rsv_ok;
        wr_old = '0;
        if (we_ok) begin
            wr_old = mem_q[bus.w1];
        end
        merged = (wr_old & ~bus.mask) | (bus.w & bus.mask);
    end

    // A reservation landing on the written register wins over release.
    always_comb begin
        busy_d = busy_q;
        clr    = 1'b0;
        if (we_ok) begin
            busy_d[bus.w1] = 1'b0;
            clr = busy_q[bus.w1] &&
                  !(fire && (bus.rsv_addr == bus.w1));
        end
        if (fire) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end
        pending_d = pending_q + (AW+1)'(fire) - (AW+1)'(clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_ok) begin
            mem_q[bus.w1] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        v1_c = '0;
        b1_c = 1'b0;
        if (in_rng(bus.r1)) begin
            v1_c = mem_q[bus.r1];
            b1_c = busy_q[bus.r1];
        end
`ifdef REGFILE_BYPASS_EN
        if (we_ok && (bus.w1 == bus.r1)) begin
            v1_c = merged;
            b1_c = fire && (bus.rsv_addr == bus.r1);
        end
`endif
    end

    always_comb begin
        v2_c = '0;
        b2_c = 1'b0;
        if (in_rng(bus.r2)) begin
            v2_c = mem_q[bus.r2];
            b2_c = busy_q[bus.r2];
        end
`ifdef REGFILE_BYPASS_EN
        if (we_ok && (bus.w1 == bus.r2)) begin
            v2_c = merged;
            b2_c = fire && (bus.rsv_addr == bus.r2);
        end
`endif
    end

    assign bus.v1        = v1_c;
    assign bus.v2        = v2_c;
    assign bus.b1        = b1_c;
    assign bus.b2        = b2_c;
    assign bus.rsv_ready = rsv_ok;
    assign bus.pending   = pending_q;

endmodule
